seq_pattern_ctrl: RTL and testbench

Programmable sequence controller for the team's 3-bit sequence counters (default pattern 0,5,7,6,3,2). It holds the pattern in a small register table and steps through it with start, stop, pause and single-step control. A loop count repeats the pattern a set number of times, or forever. The registered code output drives downstream datapath or decode logic in place of a hardwired sequence counter.

---
 rtl/seq_pattern_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_ctrl.sv
// Programmable 3-bit sequence controller: register table, loop count, pause/step.
// Optional sticky cfg_err output when SEQ_CFG_ERR_EN is defined.
module seq_pattern_ctrl #(
  parameter  int W       = 3,
  parameter  int DEPTH   = 8,
  parameter  int LEN_RST = 6,
  parameter  int CNT_W   = 8,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic [CNT_W-1:0] loops,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic [W-1:0]     cfg_data,
  input  logic             cfg_len_we,
  input  logic [IW:0]      cfg_len,
  output logic [W-1:0]     q,
  output logic [IW-1:0]    idx,
  output logic             valid,
  output logic             busy,
`ifdef SEQ_CFG_ERR_EN
  output logic             cfg_err,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     tbl [DEPTH];
  logic [IW:0]      len;
  logic [CNT_W-1:0] loop_rem;

  logic          at_end;
  logic          fin;
  logic          adv;
  logic          len_ok;
  logic [IW-1:0] nidx;

  function automatic logic [W-1:0] rst_code(input int i);
    case (i)
      1:       return W'(5);
      2:       return W'(7);
      3:       return W'(6);
      4:       return W'(3);
      5:       return W'(2);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    at_end = ({1'b0, idx} == len - (IW+1)'(1));
    fin    = at_end && (loop_rem == CNT_W'(1));
    nidx   = at_end ? '0 : idx + IW'(1);
    adv    = ((state == RUN) && !pause) ||
             ((state == PAUSE) && pause && step);
    len_ok = (cfg_len != '0) &&
             (cfg_len <= (IW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loop_rem <= '0;
      len      <= (IW+1)'(LEN_RST);
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= rst_code(i);
    end else begin
      if (cfg_we && !busy)
        tbl[cfg_addr] <= cfg_data;
      if (cfg_len_we && !busy && len_ok)
        len <= cfg_len;
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        valid <= 1'b0;
        busy  <= 1'b0;
        idx   <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state    <= RUN;
            idx      <= '0;
            q        <= tbl[0];
            valid    <= 1'b1;
            busy     <= 1'b1;
            loop_rem <= loops;
          end
          RUN:   if (pause) state <= PAUSE;
          PAUSE: if (!pause) state <= RUN;
          DONE:  state <= IDLE;
        endcase
        // Shared advance path for free-running and single-step
        if (adv) begin
          if (fin) begin
            state <= DONE;
            done  <= 1'b1;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else begin
            idx <= nidx;
            q   <= tbl[nidx];
            if (at_end && loop_rem != '0)
              loop_rem <= loop_rem - CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef SEQ_CFG_ERR_EN
  logic rej;
  assign rej = (cfg_we && busy) ||
               (cfg_len_we && (busy || !len_ok));

  always_ff @(posedge clk) begin
    if (rst)
      cfg_err <= 1'b0;
    else if (rej)
      cfg_err <= 1'b1;
    else if (state == IDLE && start && !stop)
      cfg_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Bench for seq_pattern_ctrl: position-based reference model of the
// pattern stream, directed control steps with randomized tables.
module tb_seq_pattern_ctrl;
  localparam int W = 3;
  localparam int DEPTH = 8;
  localparam int IW = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst, start, stop, pause, step;
  logic [CNT_W-1:0] loops;
  logic cfg_we, cfg_len_we;
  logic [IW-1:0] cfg_addr;
  logic [W-1:0] cfg_data;
  logic [IW:0] cfg_len;
  logic [W-1:0] q;
  logic [IW-1:0] idx;
  logic valid, busy, done;
`ifdef SEQ_CFG_ERR_EN
  logic cfg_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] mt [DEPTH];
  int mlen;

  always #5 clk = ~clk;

  seq_pattern_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .step(step), .loops(loops),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .q(q), .idx(idx), .valid(valid), .busy(busy),
`ifdef SEQ_CFG_ERR_EN
    .cfg_err(cfg_err),
`endif
    .done(done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $error("FAIL inv_done: valid=%b busy=%b", valid, busy);
        end
      end
      if (busy === 1'b1) begin
        tests++;
        if (valid !== 1'b1) begin
          fails++;
          $error("FAIL inv_busy: valid=%b", valid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mt = '{3'd0, 3'd5, 3'd7, 3'd6, 3'd3, 3'd2, 3'd0, 3'd0};
    mlen = 6;
  endtask

  task automatic expect_code(input int p);
    logic [W-1:0] eq;
    logic [IW-1:0] ei;
    eq = mt[p % mlen];
    ei = IW'(p % mlen);
    chk("q", q, eq);
    chk("idx", idx, ei);
    chk("valid", valid, 1'b1);
    chk("busy", busy, 1'b1);
    chk("done_low", done, 1'b0);
  endtask

  task automatic check_idle();
    chk("idle_valid", valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  task automatic run_seq(input int lp);
    logic [W-1:0] last;
    int total;
    total = lp * mlen;
    last = mt[(total - 1) % mlen];
    loops = CNT_W'(lp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < total; p++) begin
      expect_code(p);
      tick();
    end
    chk("done_pulse", done, 1'b1);
    chk("done_valid", valid, 1'b0);
    chk("done_busy", busy, 1'b0);
    chk("done_q", q, last);
    tick();
    check_idle();
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = IW'(a);
    cfg_data = W'(d);
    tick();
    cfg_we = 1'b0;
    mt[a] = W'(d);
  endtask

  task automatic cfg_len_write(input int l);
    cfg_len_we = 1'b1;
    cfg_len = (IW+1)'(l);
    tick();
    cfg_len_we = 1'b0;
    if (l >= 1 && l <= DEPTH) mlen = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] nv;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    pause = 1'b0; step = 1'b0; loops = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len_we = 1'b0; cfg_len = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    chk("rst_q", q, 3'd0);
    chk("rst_idx", idx, 3'd0);
    check_idle();

    run_seq(1);
    run_seq(2);

    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 36; p++) begin
      expect_code(p);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle();
    chk("stop_idx", idx, 3'd0);

    cfg_write(0, 1);
    cfg_write(1, 3);
    cfg_write(2, 7);
    cfg_write(3, 4);
    cfg_len_write(4);
    run_seq(1);

    repeat (4) begin
      for (int a = 0; a < DEPTH; a++)
        cfg_write(a, int'($urandom_range(0, 7)));
      cfg_len_write(int'($urandom_range(1, 8)));
      cfg_len_write(int'($urandom_range(9, 15)));
      run_seq(int'($urandom_range(1, 3)));
    end

    nv = ~mt[0];
    cfg_we = 1'b1;
    cfg_addr = '0;
    cfg_data = nv;
    loops = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    for (int p = 0; p < mlen; p++) begin
      expect_code(p);
      tick();
    end
    chk("sim_done", done, 1'b1);
    tick();
    mt[0] = nv;
    run_seq(1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();

    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      expect_code(p);
      if (p < 2) tick();
    end
    pause = 1'b1;
    repeat (5) begin
      tick();
      expect_code(2);
    end
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      expect_code(2 + s);
      tick();
      expect_code(2 + s);
    end
    pause = 1'b0;
    tick();
    expect_code(5);
    tick();
    expect_code(6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle();

    loops = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 5; p++) begin
      expect_code(p);
      if (p < 4) tick();
    end
    pause = 1'b1;
    tick();
    expect_code(4);
    step = 1'b1;
    tick();
    expect_code(5);
    tick();
    step = 1'b0;
    chk("step_done", done, 1'b1);
    chk("step_done_q", q, 3'd2);
    pause = 1'b0;
    tick();
    check_idle();

    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      expect_code(p);
      if (p < 3) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle();
    chk("stop6_idx", idx, 3'd0);
    tick();
    chk("stop6_nodone", done, 1'b0);

    cfg_len_write(0);
`ifdef SEQ_CFG_ERR_EN
    chk("err_len0", cfg_err, 1'b1);
`endif
    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SEQ_CFG_ERR_EN
    chk("err_start_clr", cfg_err, 1'b0);
`endif
    cfg_len_we = 1'b1;
    cfg_len = 4'd2;
    cfg_we = 1'b1;
    cfg_addr = 3'd1;
    cfg_data = 3'd0;
    tick();
    cfg_len_we = 1'b0;
    cfg_we = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
`ifdef SEQ_CFG_ERR_EN
    chk("err_busy", cfg_err, 1'b1);
`endif
    run_seq(1);

    cfg_write(1, 4);
    cfg_write(6, 1);
    cfg_len_write(8);
    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 5; p++) begin
      expect_code(p);
      if (p < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("rst2_q", q, 3'd0);
    chk("rst2_idx", idx, 3'd0);
    check_idle();
`ifdef SEQ_CFG_ERR_EN
    chk("rst2_err", cfg_err, 1'b0);
`endif
    run_seq(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
